// File: rtl/bert_pkg.sv
// bert_pkg: shared pattern encodings, tap-pair table and lock FSM state type for the BERT checker.
package bert_pkg;
  typedef enum logic [2:0] {PRBS7, PRBS9, PRBS15, PRBS23, PRBS31} poly_e;
  typedef enum logic {HUNT, LOCKED} state_e;
  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
  } tap_t;
  // Codes 5-7 fall through to PRBS31.
  function automatic tap_t taps(input logic [2:0] sel);
    case (sel)
      PRBS7:   taps = '{a: 5'd6, b: 5'd7};
      PRBS9:   taps = '{a: 5'd5, b: 5'd9};
      PRBS15:  taps = '{a: 5'd14, b: 5'd15};
      PRBS23:  taps = '{a: 5'd18, b: 5'd23};
      default: taps = '{a: 5'd28, b: 5'd31};
    endcase
  endfunction
endpackage

// File: rtl/bert_popcount.sv
// bert_popcount: combinational population count of a W-bit vector.
module bert_popcount #(
  parameter int W = 64
) (
  input  logic [W-1:0]       v,
  output logic [$clog2(W):0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt += {{$clog2(W){1'b0}}, v[i]};
  end
endmodule

// File: rtl/bert_pma_rx_chk.sv
// bert_pma_rx_chk: self-synchronising PRBS checker; 3-stage pipeline, lock FSM, saturating error counters.
module bert_pma_rx_chk
  import bert_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int CNT_W      = 32,
  parameter int LOCK_WORDS = 16,
  parameter int LOSS_WORDS = 4
) (
  input  logic             rxclk,
  input  logic             rxrst,
  input  logic             rxen,
  input  logic [2:0]       poly_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             error_counter_ce,
  input  logic             clear_counters,
  output logic             det,
  output logic             pass,
  output logic             err_word,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] word_err_cnt
);
  localparam int PW = $clog2(WIDTH) + 1;
  localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
  localparam int RW = $clog2((LOCK_WORDS > LOSS_WORDS ? LOCK_WORDS : LOSS_WORDS) + 1);
  localparam logic [SW-1:0] MAXV = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  logic [WIDTH-1:0] d1, ev, ev2;
  logic [WIDTH+30:0] ext;
  logic [30:0] hist;
  logic [2:0] poly_q;
  logic v1, v2, inv2, hist_ok, poly_chg, eval, err, inc;
  logic [PW-1:0] pc;
  logic [SW-1:0] bsum, wsum;
  logic [RW-1:0] good, good_n, bad, bad_n;
  state_e state, state_n;
  tap_t tp;
  assign poly_chg = poly_sel != poly_q;
  assign tp = taps(poly_sel);
  // Oldest history bit sits at ext[0]; the current word starts at ext[31].
  assign ext = {d1, hist};
  always_comb begin
    ev = '0;
    for (int i = 0; i < WIDTH; i++)
      ev[i] = ext[31+i] ^ ext[31+i-int'(tp.a)] ^ ext[31+i-int'(tp.b)];
  end
  always_ff @(posedge rxclk or posedge rxrst) begin
    if (rxrst) begin
      d1      <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      ev2     <= '0;
      inv2    <= 1'b0;
      hist    <= '0;
      hist_ok <= 1'b0;
      poly_q  <= '0;
    end else begin
      d1      <= data_in;
      v1      <= rxen;
      v2      <= v1;
      poly_q  <= poly_sel;
      hist_ok <= v1 ? 1'b1 : (poly_chg ? 1'b0 : hist_ok);
      if (v1) begin
        ev2  <= ev;
        inv2 <= !hist_ok || poly_chg;
        hist <= ext[WIDTH+30 -: 31];
      end
    end
  end
  bert_popcount #(.W(WIDTH)) u_popcount (.v(ev2), .cnt(pc));
  assign err  = |ev2;
  // A word still in flight when the pattern changes was checked against the old taps; drop it.
  assign eval = v2 && !inv2 && !poly_chg;
  assign inc  = eval && err && state == LOCKED && error_counter_ce;
  assign bsum = {{(SW-CNT_W){1'b0}}, bit_err_cnt} + {{(SW-PW){1'b0}}, pc};
  assign wsum = {{(SW-CNT_W){1'b0}}, word_err_cnt} + 1'b1;
  always_comb begin
    state_n = state;
    good_n  = good;
    bad_n   = bad;
    if (poly_chg) begin
      state_n = HUNT;
      good_n  = '0;
      bad_n   = '0;
    end else if (eval) begin
      if (state == HUNT) begin
        good_n  = err ? '0 : good + 1'b1;
        state_n = good_n == RW'(LOCK_WORDS) ? LOCKED : HUNT;
      end else begin
        bad_n   = err ? bad + 1'b1 : '0;
        state_n = bad_n == RW'(LOSS_WORDS) ? HUNT : LOCKED;
      end
      if (state_n != state) begin
        good_n = '0;
        bad_n  = '0;
      end
    end
  end
  always_ff @(posedge rxclk or posedge rxrst) begin
    if (rxrst) begin
      state        <= HUNT;
      good         <= '0;
      bad          <= '0;
      err_word     <= 1'b0;
      bit_err_cnt  <= '0;
      word_err_cnt <= '0;
    end else begin
      state    <= state_n;
      good     <= good_n;
      bad      <= bad_n;
      err_word <= eval && err;
      if (clear_counters) begin
        bit_err_cnt  <= '0;
        word_err_cnt <= '0;
      end else if (inc) begin
        bit_err_cnt  <= bsum > MAXV ? {CNT_W{1'b1}} : bsum[CNT_W-1:0];
        word_err_cnt <= wsum > MAXV ? {CNT_W{1'b1}} : wsum[CNT_W-1:0];
      end
    end
  end
  assign det  = state == LOCKED;
  assign pass = det && word_err_cnt == '0;
endmodule

// File: tb/tb_bert_pma_rx_chk.sv
// tb_bert_pma_rx_chk: scoreboard bench driving two checker instances (default and 4-bit counters) from one stream.
module tb_bert_pma_rx_chk;
  localparam int W = 64;
  typedef struct {
    int   due;
    logic inval;
    int   pc;
  } ent_t;
  logic rxclk = 1'b0, rxrst = 1'b1, rxen = 1'b0, error_counter_ce = 1'b1, clear_counters = 1'b0;
  logic [2:0] poly_sel = 3'd4;
  logic [W-1:0] data_in = '0;
  logic det_a, pass_a, err_word_a, det_b, pass_b, err_word_b;
  logic [31:0] bit_err_cnt_a, word_err_cnt_a;
  logic [3:0] bit_err_cnt_b, word_err_cnt_b;
  int checks = 0, failures = 0, cyc = 0;
  ent_t q[$];
  logic [63:0] gen = 64'hdead_beef_1234_5678, line = '0;
  logic need_inval = 1'b1, exp_ew = 1'b0;
  logic [2:0] prev_poly = '0;
  logic st[2];
  int good[2], bad[2];
  longint wc[2], bc[2];
  int loss[2] = '{4, 1000};
  longint cmax[2] = '{64'hffff_ffff, 15};

  bert_pma_rx_chk #(.WIDTH(W)) dut_a (
    .rxclk(rxclk), .rxrst(rxrst), .rxen(rxen), .poly_sel(poly_sel), .data_in(data_in),
    .error_counter_ce(error_counter_ce), .clear_counters(clear_counters),
    .det(det_a), .pass(pass_a), .err_word(err_word_a),
    .bit_err_cnt(bit_err_cnt_a), .word_err_cnt(word_err_cnt_a)
  );
  bert_pma_rx_chk #(.WIDTH(W), .CNT_W(4), .LOSS_WORDS(1000)) dut_b (
    .rxclk(rxclk), .rxrst(rxrst), .rxen(rxen), .poly_sel(poly_sel), .data_in(data_in),
    .error_counter_ce(error_counter_ce), .clear_counters(clear_counters),
    .det(det_b), .pass(pass_b), .err_word(err_word_b),
    .bit_err_cnt(bit_err_cnt_b), .word_err_cnt(word_err_cnt_b)
  );

  always #5 rxclk = ~rxclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int tap_a(input logic [2:0] p);
    return p == 0 ? 6 : p == 1 ? 5 : p == 2 ? 14 : p == 3 ? 18 : 28;
  endfunction

  function automatic int tap_b(input logic [2:0] p);
    return p == 0 ? 7 : p == 1 ? 9 : p == 2 ? 15 : p == 3 ? 23 : 31;
  endfunction

  // Drives one cycle, predicts the state after its closing edge, then compares both instances.
  task automatic step(input logic en, input logic [W-1:0] flip, input logic clr, input logic [2:0] p);
    ent_t e;
    logic [W-1:0] w;
    logic pchg, nb;
    int a, b;
    pchg = p != prev_poly;
    a = tap_a(p);
    b = tap_b(p);
    if (pchg) begin
      if (q.size() > 0 && q[$].due == cyc + 1) q[$].inval = 1'b1;
      else need_inval = 1'b1;
    end
    w = {$urandom, $urandom};
    if (en) begin
      e.pc = 0;
      for (int i = 0; i < W; i++) begin
        nb = gen[a-1] ^ gen[b-1];
        gen = {gen[62:0], nb};
        w[i] = nb ^ flip[i];
        e.pc += int'(w[i] ^ line[a-1] ^ line[b-1]);
        line = {line[62:0], w[i]};
      end
      e.due = cyc + 2;
      e.inval = need_inval;
      need_inval = 1'b0;
      q.push_back(e);
    end
    rxen = en;
    data_in = w;
    clear_counters = clr;
    poly_sel = p;
    exp_ew = 1'b0;
    if (pchg) begin
      for (int k = 0; k < 2; k++) begin
        st[k] = 1'b0;
        good[k] = 0;
        bad[k] = 0;
      end
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (!e.inval) begin
        exp_ew = e.pc != 0;
        for (int k = 0; k < 2; k++) begin
          if (st[k] && error_counter_ce && exp_ew) begin
            wc[k] = wc[k] + 1 > cmax[k] ? cmax[k] : wc[k] + 1;
            bc[k] = bc[k] + e.pc > cmax[k] ? cmax[k] : bc[k] + e.pc;
          end
          if (!st[k]) begin
            good[k] = exp_ew ? 0 : good[k] + 1;
            if (good[k] == 16) begin
              st[k] = 1'b1;
              good[k] = 0;
              bad[k] = 0;
            end
          end else begin
            bad[k] = exp_ew ? bad[k] + 1 : 0;
            if (bad[k] == loss[k]) begin
              st[k] = 1'b0;
              good[k] = 0;
              bad[k] = 0;
            end
          end
        end
      end
    end
    if (clr) for (int k = 0; k < 2; k++) begin
      wc[k] = 0;
      bc[k] = 0;
    end
    prev_poly = p;
    @(posedge rxclk);
    #1;
    check_eq("det_a", det_a, st[0]);
    check_eq("pass_a", pass_a, st[0] && wc[0] == 0);
    check_eq("err_word_a", err_word_a, exp_ew);
    check_eq("word_cnt_a", word_err_cnt_a, wc[0]);
    check_eq("bit_cnt_a", bit_err_cnt_a, bc[0]);
    check_eq("det_b", det_b, st[1]);
    check_eq("pass_b", pass_b, st[1] && wc[1] == 0);
    check_eq("err_word_b", err_word_b, exp_ew);
    check_eq("word_cnt_b", word_err_cnt_b, wc[1]);
    check_eq("bit_cnt_b", bit_err_cnt_b, bc[1]);
    @(negedge rxclk);
    cyc++;
  endtask

  initial begin
    logic en;
    int nv;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0;
      good[k] = 0;
      bad[k] = 0;
      wc[k] = 0;
      bc[k] = 0;
    end
    repeat (3) @(negedge rxclk);
    check_eq("rst_det", det_a, 0);
    check_eq("rst_pass", pass_a, 0);
    check_eq("rst_err_word", err_word_a, 0);
    check_eq("rst_word_cnt", word_err_cnt_a, 0);
    check_eq("rst_bit_cnt", bit_err_cnt_a, 0);
    check_eq("rst_det_b", det_b, 0);
    rxrst = 1'b0;
    repeat (30) step(1'b1, '0, 1'b0, 3'd4);
    check_eq("lock_prbs31", det_a, 1);
    check_eq("pass_prbs31", pass_a, 1);
    step(1'b1, 64'h400, 1'b0, 3'd4);
    repeat (6) step(1'b1, '0, 1'b0, 3'd4);
    check_eq("flip_word_cnt", word_err_cnt_a, 1);
    check_eq("flip_bit_cnt", bit_err_cnt_a, 3);
    check_eq("flip_det", det_a, 1);
    repeat (4) step(1'b1, 64'h1, 1'b0, 3'd4);
    repeat (2) step(1'b1, '0, 1'b0, 3'd4);
    check_eq("loss_det", det_a, 0);
    repeat (18) step(1'b1, '0, 1'b0, 3'd4);
    check_eq("relock_det", det_a, 1);
    repeat (20) step(1'b1, 64'h20, 1'b0, 3'd4);
    repeat (2) step(1'b1, '0, 1'b0, 3'd4);
    check_eq("sat_word_b", word_err_cnt_b, 15);
    check_eq("sat_bit_b", bit_err_cnt_b, 15);
    check_eq("sat_det_b", det_b, 1);
    repeat (20) step(1'b1, '0, 1'b0, 3'd4);
    step(1'b1, 64'h100, 1'b0, 3'd4);
    step(1'b1, '0, 1'b0, 3'd4);
    step(1'b1, '0, 1'b1, 3'd4);
    check_eq("clr_word_cnt", word_err_cnt_a, 0);
    check_eq("clr_bit_cnt", bit_err_cnt_a, 0);
    check_eq("clr_word_cnt_b", word_err_cnt_b, 0);
    step(1'b1, '0, 1'b0, 3'd0);
    check_eq("poly_switch_det", det_a, 0);
    repeat (3) step(1'b1, '0, 1'b0, 3'd0);
    step(1'b1, 64'h1000, 1'b0, 3'd0);
    repeat (20) step(1'b1, '0, 1'b0, 3'd0);
    check_eq("prbs7_det", det_a, 1);
    check_eq("prbs7_hunt_no_count", word_err_cnt_a, 0);
    step(1'b1, '0, 1'b1, 3'd0);
    nv = 0;
    while (nv < 30) begin
      en = 1'($urandom_range(0, 1));
      step(en, (en && nv == 10) ? 64'h8 : 64'h0, 1'b0, 3'd0);
      if (en) nv++;
    end
    repeat (3) step(1'b1, '0, 1'b0, 3'd0);
    check_eq("gap_det", det_a, 1);
    check_eq("gap_word_cnt", word_err_cnt_a, 1);
    check_eq("gap_bit_cnt", bit_err_cnt_a, 3);
    repeat (200) begin
      en = 1'($urandom_range(0, 1));
      step(en, (en && $urandom_range(0, 30) == 0) ? 64'h1 << $urandom_range(0, 63) : 64'h0, 1'b0, 3'd0);
    end
    repeat (40) step(1'b1, '0, 1'b0, 3'd0);
    check_eq("final_det", det_a, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bert_pma_rx_chk.md
BERT_PMA_RX_CHK -- requirements
Module: bert_pma_rx_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data word width; legal values 16, 32, 64.
REQ-002 SHALL have parameter CNT_W, default 32: error counter width.
REQ-003 SHALL have parameter LOCK_WORDS, default 16: consecutive clean words needed to lock.
REQ-004 SHALL have parameter LOSS_WORDS, default 4: consecutive errored words that drop lock.
REQ-005 SHALL have port rxclk, input, 1: sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rxrst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rxen, input, 1: data_in is valid this cycle.
REQ-008 SHALL have port poly_sel, input, 3: pattern select. 0=PRBS7, 1=PRBS9, 2=PRBS15, 3=PRBS23, 4=PRBS31; 5-7 are treated as PRBS31.
REQ-009 SHALL have port data_in, input, WIDTH: received word; bit 0 is the oldest bit on the line.
REQ-010 SHALL have port error_counter_ce, input, 1: enables error accumulation.
REQ-011 SHALL have port clear_counters, input, 1: synchronous clear of both counters.
REQ-012 SHALL have port det, output, 1: pattern locked.
REQ-013 SHALL have port pass, output, 1: locked and word_err_cnt == 0.
REQ-014 SHALL have port err_word, output, 1: one-cycle pulse for an errored evaluated word.
REQ-015 SHALL have port bit_err_cnt, output, CNT_W: saturating count of errored bits.
REQ-016 SHALL have port word_err_cnt, output, CNT_W: saturating count of errored words.

Function
REQ-017 SHALL check using a self-synchronising method: bit b[n] is in error iff b[n] != b[n-A]^b[n-B].
REQ-018 SHALL use (A,B) = (6,7) PRBS7, (5,9) PRBS9, (14,15) PRBS15, (18,23) PRBS23, (28,31) PRBS31.
REQ-019 SHALL keep a 31-bit history of the last received bits, updated only when rxen=1; bits older than the current word come from this history.
REQ-020 SHALL run a 3-stage pipeline:
- S1 registers data_in and rxen.
- S2 registers the WIDTH-bit error vector.
- S3 registers err_word, the counters and the FSM state.
REQ-021 SHALL give latency: a word presented at cycle N affects err_word and the FSM at the rxclk edge ending cycle N+2, and the counters at the same edge.
REQ-022 SHALL NOT evaluate, count or advance the FSM in cycles where rxen=0; pipeline stages carry a valid bit.
REQ-023 SHALL treat the first evaluated word after reset or a poly_sel change as history-invalid: it is not counted, and the FSM stays in HUNT.
REQ-024 SHALL implement FSM states:
- HUNT (reset state): clean-run counter increments per clean word and clears on an errored word; reaching LOCK_WORDS goes to LOCKED and sets det=1.
- LOCKED: bad-run counter increments per errored word and clears on a clean word; reaching LOSS_WORDS goes to HUNT and sets det=0.
REQ-025 SHALL force HUNT on the cycle after any poly_sel change, clearing both run counters.
REQ-026 SHALL increment counters only when state==LOCKED, error_counter_ce=1 and the word is errored:
- word_err_cnt increases by 1.
- bit_err_cnt increases by popcount(error vector).
REQ-027 SHALL saturate both counters at 2^CNT_W-1; the addition is done at CNT_W+1 bits and clamped, never wrapping.
REQ-028 SHALL let clear_counters take priority over a simultaneous increment; the counters read 0 on the next cycle.
REQ-029 SHALL pulse err_word for any errored evaluated word regardless of FSM state or error_counter_ce.
REQ-030 SHALL note that one injected line bit error yields 3 flagged bits across the tap positions; this is expected and not compensated.

Reset
REQ-031 SHALL, on rxrst asserted, asynchronously set:
- det=0, pass=0, err_word=0.
- bit_err_cnt=0, word_err_cnt=0.
- state=HUNT, run counters=0.
- history=0, all pipeline valid bits=0.
REQ-032 SHALL, when rxrst asserts mid-lock, abandon lock immediately and require LOCK_WORDS clean words again after release.

Structure
REQ-033 SHALL place in the shared bert package:
- the poly_sel encodings;
- the tap-pair table (A,B) per pattern;
- the FSM state typedef.
REQ-034 SHALL put the WIDTH-bit population count in sub-module bert_popcount (parametrised width, combinational, output width clog2(WIDTH)+1).

Verification
REQ-035 SHALL test: WIDTH=64, PRBS31 clean stream, rxen=1 -> det=1 after 1+16 evaluated words plus pipeline latency; pass=1; counters stay 0.
REQ-036 SHALL test: locked, ce=1, flip data_in bit 10 once -> err_word single pulse; word_err_cnt=1 (or 2 if taps straddle words); bit_err_cnt=3; det stays 1.
REQ-037 SHALL test: locked, inject errors into 4 consecutive words -> det=0 after the 4th; a following clean stream relocks after 16 words.
REQ-038 SHALL test: CNT_W=4, ce=1, sustained errors while LOCKED (LOSS_WORDS set large) -> both counters hold at 15, with no wrap.
REQ-039 SHALL test: switch poly_sel PRBS31->PRBS7 while locked, then feed PRBS7 -> det=0 the next cycle, relock on PRBS7, with no counting during HUNT.
REQ-040 SHALL test: clear_counters asserted in the same cycle as an errored locked word -> counters read 0; also toggle rxen pseudo-randomly and expect identical lock and count results.
